// File: rtl/aes_pkg.sv
// Shared definitions for the AES round stages: block width and block/key type.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    function automatic aes_block_t add_round_key(input aes_block_t state, input aes_block_t key);
        return state ^ key;
    endfunction

endpackage

// File: rtl/add_round_key_stream_if.sv
// Data, round-key and output channels of the AddRoundKey stream stage.
interface add_round_key_stream_if #(
    parameter int DATA_W    = 128,
    parameter int KEY_DEPTH = 4,
    parameter int TAG_W     = 4
);
    localparam int CNT_W = $clog2(KEY_DEPTH) + 1;

    logic              data_valid_in;
    logic              data_ready_out;
    logic [DATA_W-1:0] data_in;
    logic [TAG_W-1:0]  tag_in;
    logic              key_hold_in;
    logic              key_valid_in;
    logic              key_ready_out;
    logic [DATA_W-1:0] round_key;
    logic              valid_out;
    logic              ready_in;
    logic [DATA_W-1:0] data_out;
    logic [TAG_W-1:0]  tag_out;
    logic [CNT_W-1:0]  key_count;

    modport master (
        output data_valid_in, data_in, tag_in, key_hold_in,
        output key_valid_in, round_key, ready_in,
        input  data_ready_out, key_ready_out, valid_out, data_out, tag_out, key_count
    );

    modport slave (
        input  data_valid_in, data_in, tag_in, key_hold_in,
        input  key_valid_in, round_key, ready_in,
        output data_ready_out, key_ready_out, valid_out, data_out, tag_out, key_count
    );

endinterface

// File: rtl/add_round_key_stream_key_fifo.sv
// Round-key FIFO: power-of-two depth, wrap-around pointers, synchronous flush.
module ark_key_fifo #(
    parameter  int DATA_W    = 128,
    parameter  int KEY_DEPTH = 4,
    localparam int AW        = $clog2(KEY_DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [KEY_DEPTH];
    logic [DATA_W-1:0] mem_d [KEY_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (count_q == CW'(KEY_DEPTH));
    assign empty     = (count_q == CW'(0));
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Next-state pointers, occupancy and storage; flush overrides push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = AW'(0);
            rd_ptr_d = AW'(0);
            count_d  = CW'(0);
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Key storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/add_round_key_stream.sv
// Streaming AddRoundKey: buffered round keys XORed into data blocks, registered output.
module add_round_key_stream
    import aes_pkg::*;
#(
    parameter int DATA_W    = AES_BLOCK_W,
    parameter int KEY_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    add_round_key_stream_if.slave  bus
);

    localparam int CNT_W = $clog2(KEY_DEPTH) + 1;

    logic [DATA_W-1:0] head_key_s;
    logic [CNT_W-1:0]  key_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              out_free_s;
    logic              data_ready_s;
    logic              accept_s;
    logic              key_push_s;
    logic              key_pop_s;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    // Readiness depends on registered state only, so a key landing this cycle cannot serve data.
    assign out_free_s   = ~valid_q | bus.ready_in;
    assign data_ready_s = ~fifo_empty_s & out_free_s;
    assign accept_s     = bus.data_valid_in & data_ready_s;
    assign key_pop_s    = accept_s & ~bus.key_hold_in;
    assign key_push_s   = bus.key_valid_in & ~fifo_full_s;

    ark_key_fifo #(
        .DATA_W    (DATA_W),
        .KEY_DEPTH (KEY_DEPTH)
    ) u_key_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (key_push_s),
        .pop   (key_pop_s),
        .wdata (bus.round_key),
        .rdata (head_key_s),
        .count (key_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Output stage next state; flush drops the pending beat but leaves data/tag untouched.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d = 1'b1;
            data_d  = bus.data_in ^ head_key_s;
            tag_d   = bus.tag_in;
        end else if (bus.ready_in) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
            tag_q   <= {TAG_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.data_ready_out = data_ready_s;
    assign bus.key_ready_out  = ~fifo_full_s;
    assign bus.valid_out      = valid_q;
    assign bus.data_out       = data_q;
    assign bus.tag_out        = tag_q;
    assign bus.key_count      = key_count_s;

endmodule
